// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the packet FIFO: FSM encoding, Gray conversion, counter width.
package fifo_pkt_pkg;

  localparam int DROP_CNT_W = 16;
  // Widest pointer supported (ADDR_WIDTH up to 10, plus the wrap bit)
  localparam int PTR_MAX_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_pkt_gray_sync.sv
// Brings the reader's Gray pointer into the write domain through a flop chain
// and presents it as binary; the chain resets to zero with the write side.
module fifo_pkt_gray_sync
  import fifo_pkt_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         wr_clk,
  input  logic         asyn_rst,
  input  logic [W-1:0] gray,
  output logic [W-1:0] rp
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rp = W'(gray2bin(PTR_MAX_W'(sync_q[STAGES-1])));

endmodule

// File: rtl/fifo_pkt_wr_ctrl.sv
// Packet FIFO write controller: writes beats at a tentative pointer and publishes
// the pointer (Gray, registered) only on a clean eop; bad packets are rewound and counted.
module fifo_pkt_wr_ctrl
  import fifo_pkt_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sop,
  input  logic                  s_eop,
  input  logic                  s_err,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  pkt_commit,
  output logic [DROP_CNT_W-1:0] pkt_drop_cnt
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t        state, state_nxt;
  logic [PW-1:0] wp_tmp, wp_tmp_nxt;
  logic [PW-1:0] wp_cmt, wp_cmt_nxt;
  logic [PW-1:0] rp;
  logic [PW-1:0] wr_ptr;
  logic          wr_en_nxt;
  logic          commit;
  logic [1:0]    drop_inc;
  logic          ready_nxt;
  logic          acc;
  logic          tmp_full;
  logic [DROP_CNT_W:0] drop_sum;

  fifo_pkt_gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rp_sync (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .gray     (rd_ptr_gray_i),
    .rp       (rp)
  );

  assign acc      = s_valid & s_ready;
  assign tmp_full = (wp_tmp - rp) == DEPTH;

  always_comb begin
    state_nxt  = state;
    wp_tmp_nxt = wp_tmp;
    wp_cmt_nxt = wp_cmt;
    wr_ptr     = wp_tmp;
    wr_en_nxt  = 1'b0;
    commit     = 1'b0;
    drop_inc   = 2'd0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (s_sop) begin
            wr_en_nxt = 1'b1;
            if (!s_eop) begin
              wp_tmp_nxt = wp_tmp + 1'b1;
              state_nxt  = WRITE;
            end else if (s_err) begin
              drop_inc = 2'd1;
            end else begin
              commit     = 1'b1;
              wp_tmp_nxt = wp_tmp + 1'b1;
              wp_cmt_nxt = wp_tmp + 1'b1;
            end
          end
        end
        WRITE: begin
          if (s_sop) begin
            // Restart: old packet is abandoned, new one begins at the committed pointer
            drop_inc  = 2'd1;
            wr_en_nxt = 1'b1;
            wr_ptr    = wp_cmt;
            if (!s_eop) begin
              wp_tmp_nxt = wp_cmt + 1'b1;
            end else if (s_err) begin
              drop_inc   = 2'd2;
              wp_tmp_nxt = wp_cmt;
              state_nxt  = IDLE;
            end else begin
              commit     = 1'b1;
              wp_tmp_nxt = wp_cmt + 1'b1;
              wp_cmt_nxt = wp_cmt + 1'b1;
              state_nxt  = IDLE;
            end
          end else if (tmp_full) begin
            drop_inc   = 2'd1;
            wp_tmp_nxt = wp_cmt;
            state_nxt  = s_eop ? IDLE : DROP;
          end else begin
            wr_en_nxt = 1'b1;
            if (!s_eop) begin
              wp_tmp_nxt = wp_tmp + 1'b1;
            end else if (s_err) begin
              drop_inc   = 2'd1;
              wp_tmp_nxt = wp_cmt;
              state_nxt  = IDLE;
            end else begin
              commit     = 1'b1;
              wp_tmp_nxt = wp_tmp + 1'b1;
              wp_cmt_nxt = wp_tmp + 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
        DROP: begin
          if (s_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A stale rp only overstates fullness, so registering ready from it stays safe
  assign ready_nxt = (state_nxt != IDLE) || ((wp_cmt_nxt - rp) != DEPTH);
  assign drop_sum  = {1'b0, pkt_drop_cnt} + {{(DROP_CNT_W-1){1'b0}}, drop_inc};

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state         <= IDLE;
      wp_tmp        <= '0;
      wp_cmt        <= '0;
      s_ready       <= 1'b0;
      ram_wr_en     <= 1'b0;
      ram_wr_addr   <= '0;
      ram_wr_data   <= '0;
      wr_ptr_gray_o <= '0;
      wr_level      <= '0;
      pkt_commit    <= 1'b0;
      pkt_drop_cnt  <= '0;
    end else begin
      state         <= state_nxt;
      wp_tmp        <= wp_tmp_nxt;
      wp_cmt        <= wp_cmt_nxt;
      s_ready       <= ready_nxt;
      ram_wr_en     <= wr_en_nxt;
      if (wr_en_nxt) begin
        ram_wr_addr <= wr_ptr[ADDR_WIDTH-1:0];
        ram_wr_data <= s_data;
      end
      wr_ptr_gray_o <= PW'(bin2gray(PTR_MAX_W'(wp_cmt)));
      wr_level      <= wp_cmt - rp;
      pkt_commit    <= commit;
      pkt_drop_cnt  <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fifo_pkt_wr_ctrl.sv
// Directed bench for the packet FIFO write controller (depth 16, two sync stages).
module tb_fifo_pkt_wr_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          wr_clk = 1'b0;
  logic          asyn_rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, s_err = 1'b0;
  logic          s_ready;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [AW:0]   rd_ptr_gray_i = '0;
  logic [AW:0]   wr_ptr_gray_o;
  logic [AW:0]   wr_level;
  logic          pkt_commit;
  logic [15:0]   pkt_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_commit = 0;
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];

  always #5 wr_clk = ~wr_clk;

  fifo_pkt_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .wr_clk        (wr_clk),
    .asyn_rst      (asyn_rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sop         (s_sop),
    .s_eop         (s_eop),
    .s_err         (s_err),
    .s_ready       (s_ready),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_en     (ram_wr_en),
    .rd_ptr_gray_i (rd_ptr_gray_i),
    .wr_ptr_gray_o (wr_ptr_gray_o),
    .wr_level      (wr_level),
    .pkt_commit    (pkt_commit),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  always @(negedge wr_clk) begin
    if (ram_wr_en) begin
      log_addr.push_back(ram_wr_addr);
      log_data.push_back(ram_wr_data);
    end
    if (pkt_commit) n_commit++;
  end

  function automatic logic [AW:0] g(input int x);
    logic [AW:0] b;
    b = x[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    n_commit = 0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop, input logic err);
    int to;
    @(negedge wr_clk);
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_err = err;
    to = 0;
    while (!s_ready) begin
      to++;
      if (to > 40) begin
        check("s_ready_wait", {31'd0, s_ready}, 32'd1);
        break;
      end
      @(negedge wr_clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge wr_clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_err = 1'b0;
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic send_pkt(input int n, input logic [DW-1:0] base, input logic err);
    for (int i = 0; i < n; i++)
      beat(base + DW'(i), i == 0, i == n-1, err && (i == n-1));
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    asyn_rst = 1'b1; rd_ptr_gray_i = '0; s_valid = 1'b0;
    repeat (2) @(negedge wr_clk);
    asyn_rst = 1'b0;
    repeat (2) @(negedge wr_clk);
    clear_log();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge wr_clk);
    check("rst_s_ready", {31'd0, s_ready}, 0);
    check("rst_wr_en", {31'd0, ram_wr_en}, 0);
    check("rst_gray", 32'(wr_ptr_gray_o), 0);
    check("rst_level", 32'(wr_level), 0);
    check("rst_drop", 32'(pkt_drop_cnt), 0);
    do_reset();
    check("idle_s_ready", {31'd0, s_ready}, 1);

    // 1: clean 4-beat packet
    send_pkt(4, 8'hA1, 1'b0);
    check("t1_nwr", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(log_addr[i]), i);
      check("t1_data", 32'(log_data[i]), 32'hA1 + i);
    end
    check("t1_gray", 32'(wr_ptr_gray_o), 32'h06);
    check("t1_commits", n_commit, 1);
    check("t1_level", 32'(wr_level), 4);

    // 2: errored packet is rewound
    do_reset();
    send_pkt(3, 8'hB0, 1'b1);
    check("t2_nwr", log_addr.size(), 3);
    check("t2_gray", 32'(wr_ptr_gray_o), 0);
    check("t2_drop", 32'(pkt_drop_cnt), 1);
    check("t2_commits", n_commit, 0);
    clear_log();
    send_pkt(2, 8'hC0, 1'b0);
    check("t2_next_addr", 32'(log_addr[0]), 0);
    check("t2_next_gray", 32'(wr_ptr_gray_o), 32'(g(2)));

    // 3: overflowing packet
    do_reset();
    send_pkt(20, 8'h10, 1'b0);
    check("t3_nwr", log_addr.size(), 16);
    for (int i = 0; i < 16; i++) check("t3_addr", 32'(log_addr[i]), i);
    check("t3_drop", 32'(pkt_drop_cnt), 1);
    check("t3_level", 32'(wr_level), 0);
    check("t3_s_ready", {31'd0, s_ready}, 1);

    // 4: full FIFO blocks in IDLE until the reader advances
    do_reset();
    send_pkt(8, 8'h20, 1'b0);
    send_pkt(8, 8'h30, 1'b0);
    check("t4_full_ready", {31'd0, s_ready}, 0);
    check("t4_full_level", 32'(wr_level), 16);
    @(negedge wr_clk);
    rd_ptr_gray_i = g(8);
    repeat (SS) @(negedge wr_clk);
    check("t4_ready_early", {31'd0, s_ready}, 0);
    @(negedge wr_clk);
    check("t4_ready", {31'd0, s_ready}, 1);
    check("t4_level", 32'(wr_level), 8);

    // 5: pointer wrap
    do_reset();
    begin
      int wp = 0;
      int sizes [4] = '{8, 8, 8, 6};
      for (int k = 0; k < 4; k++) begin
        send_pkt(sizes[k], 8'h40, 1'b0);
        wp += sizes[k];
        rd_ptr_gray_i = g(wp);
        repeat (4) @(negedge wr_clk);
      end
    end
    check("t5_level0", 32'(wr_level), 0);
    clear_log();
    send_pkt(4, 8'h50, 1'b0);
    check("t5_a0", 32'(log_addr[0]), 14);
    check("t5_a1", 32'(log_addr[1]), 15);
    check("t5_a2", 32'(log_addr[2]), 0);
    check("t5_a3", 32'(log_addr[3]), 1);
    check("t5_gray", 32'(wr_ptr_gray_o), 32'(g(2)));
    check("t5_level", 32'(wr_level), 4);
    send_pkt(1, 8'h60, 1'b1);
    check("t5_drop", 32'(pkt_drop_cnt), 1);

    // 6: reset mid-packet
    beat(8'h70, 1'b1, 1'b0, 1'b0);
    beat(8'h71, 1'b0, 1'b0, 1'b0);
    @(negedge wr_clk);
    asyn_rst = 1'b1; rd_ptr_gray_i = '0; s_valid = 1'b0;
    #1;
    check("t6_s_ready", {31'd0, s_ready}, 0);
    check("t6_gray", 32'(wr_ptr_gray_o), 0);
    check("t6_level", 32'(wr_level), 0);
    check("t6_drop", 32'(pkt_drop_cnt), 0);
    check("t6_wr_en", {31'd0, ram_wr_en}, 0);
    repeat (2) @(negedge wr_clk);
    asyn_rst = 1'b0;
    repeat (2) @(negedge wr_clk);
    clear_log();
    beat(8'h80, 1'b0, 1'b0, 1'b0);
    beat(8'h81, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("t6_nosop_nwr", log_addr.size(), 0);
    send_pkt(2, 8'h90, 1'b0);
    check("t6_a0", 32'(log_addr[0]), 0);
    check("t6_a1", 32'(log_addr[1]), 1);
    check("t6_gray2", 32'(wr_ptr_gray_o), 32'(g(2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
